// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - two-port arbiter sharing one 16-bit shifter
//
// Two requesters (A and B) share a single 16-bit shift datapath. At most one
// operation is accepted per cycle. Each port owns a one-entry result buffer
// with a valid/ready handshake.
//
// Parameters
//   FAIR      1 = round-robin between ports, 0 = fixed priority with A highest
//
// Ports (X = a or b)
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   X_req     operation request, held with operands until X_gnt
//   X_src     16-bit shift source
//   X_shamt   shift amount 0-15
//   X_dir     01 SLL, 10 SRL, 11 SRA, 00 pass-through
//   X_gnt     combinational accept strobe for this cycle
//   X_vld     result buffer full
//   X_rdy     consumer takes the result when X_vld & X_rdy
//   X_res     buffered shift result
//   X_zr      1 when X_res == 0
module shift_arbiter #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic [15:0] a_src,
    input  logic [3:0]  a_shamt,
    input  logic [1:0]  a_dir,
    output logic        a_gnt,
    output logic        a_vld,
    input  logic        a_rdy,
    output logic [15:0] a_res,
    output logic        a_zr,

    input  logic        b_req,
    input  logic [15:0] b_src,
    input  logic [3:0]  b_shamt,
    input  logic [1:0]  b_dir,
    output logic        b_gnt,
    output logic        b_vld,
    input  logic        b_rdy,
    output logic [15:0] b_res,
    output logic        b_zr
);

    localparam bit FIXED_PRIO = (FAIR == 0);

    localparam logic [1:0] DIR_PASS = 2'b00;
    localparam logic [1:0] DIR_SLL  = 2'b01;
    localparam logic [1:0] DIR_SRL  = 2'b10;
    localparam logic [1:0] DIR_SRA  = 2'b11;

    // 1 when B was the most recently granted port; reset makes A win the first tie.
    logic last_b;

    logic a_elig;
    logic b_elig;
    logic pick_a;

    logic [15:0] op_src;
    logic [3:0]  op_shamt;
    logic [1:0]  op_dir;
    logic [15:0] sh_res;

    // A port may take a new operation when its buffer is empty or is being
    // drained in this same cycle.
    always_comb begin
        a_elig = a_req && (!a_vld || a_rdy);
        b_elig = b_req && (!b_vld || b_rdy);
        pick_a = a_elig && (!b_elig || FIXED_PRIO || last_b);
        a_gnt  = !rst && pick_a;
        b_gnt  = !rst && b_elig && !pick_a;
    end

    // Single shared shifter; operands come from whichever port is granted.
    always_comb begin
        if (b_gnt) begin
            op_src   = b_src;
            op_shamt = b_shamt;
            op_dir   = b_dir;
        end else begin
            op_src   = a_src;
            op_shamt = a_shamt;
            op_dir   = a_dir;
        end

        case (op_dir)
            DIR_SLL:  sh_res = op_src << op_shamt;
            DIR_SRL:  sh_res = op_src >> op_shamt;
            DIR_SRA:  sh_res = $unsigned($signed(op_src) >>> op_shamt);
            DIR_PASS: sh_res = op_src;
            default:  sh_res = op_src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld  <= 1'b0;
            a_res  <= 16'h0000;
            a_zr   <= 1'b0;
            b_vld  <= 1'b0;
            b_res  <= 16'h0000;
            b_zr   <= 1'b0;
            last_b <= 1'b1;
        end else begin
            if (a_gnt) begin
                a_vld <= 1'b1;
                a_res <= sh_res;
                a_zr  <= (sh_res == 16'h0000);
            end else if (a_vld && a_rdy) begin
                a_vld <= 1'b0;
            end

            if (b_gnt) begin
                b_vld <= 1'b1;
                b_res <= sh_res;
                b_zr  <= (sh_res == 16'h0000);
            end else if (b_vld && b_rdy) begin
                b_vld <= 1'b0;
            end

            if (a_gnt) begin
                last_b <= 1'b0;
            end else if (b_gnt) begin
                last_b <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - bench for shift_arbiter, round-robin and fixed-priority builds side by side
module tb_shift_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Shared stimulus, index 0 = port A, 1 = port B.
    logic        req   [2];
    logic [15:0] src   [2];
    logic [3:0]  shamt [2];
    logic [1:0]  dir   [2];
    logic        rdy   [2];

    // DUT outputs, first index 0 = FAIR=1 build, 1 = FAIR=0 build.
    logic        d_gnt [2][2];
    logic        d_vld [2][2];
    logic [15:0] d_res [2][2];
    logic        d_zr  [2][2];

    shift_arbiter #(.FAIR(1)) u_fair (
        .clk(clk), .rst(rst),
        .a_req(req[0]), .a_src(src[0]), .a_shamt(shamt[0]), .a_dir(dir[0]),
        .a_gnt(d_gnt[0][0]), .a_vld(d_vld[0][0]), .a_rdy(rdy[0]),
        .a_res(d_res[0][0]), .a_zr(d_zr[0][0]),
        .b_req(req[1]), .b_src(src[1]), .b_shamt(shamt[1]), .b_dir(dir[1]),
        .b_gnt(d_gnt[0][1]), .b_vld(d_vld[0][1]), .b_rdy(rdy[1]),
        .b_res(d_res[0][1]), .b_zr(d_zr[0][1])
    );

    shift_arbiter #(.FAIR(0)) u_prio (
        .clk(clk), .rst(rst),
        .a_req(req[0]), .a_src(src[0]), .a_shamt(shamt[0]), .a_dir(dir[0]),
        .a_gnt(d_gnt[1][0]), .a_vld(d_vld[1][0]), .a_rdy(rdy[0]),
        .a_res(d_res[1][0]), .a_zr(d_zr[1][0]),
        .b_req(req[1]), .b_src(src[1]), .b_shamt(shamt[1]), .b_dir(dir[1]),
        .b_gnt(d_gnt[1][1]), .b_vld(d_vld[1][1]), .b_rdy(rdy[1]),
        .b_res(d_res[1][1]), .b_zr(d_zr[1][1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what each buffer should hold and who was last served.
    logic        m_vld  [2][2];
    logic [15:0] m_res  [2][2];
    logic        m_zr   [2][2];
    int          m_last [2];     // port index last granted
    logic        s_gnt  [2][2];  // grants sampled during the last cycle()

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Shift computed with plain integer arithmetic.
    function automatic logic [15:0] ref_shift(input logic [15:0] s, input logic [3:0] n,
                                              input logic [1:0] op);
        longint v, d, q;
        d = longint'(1) << n;
        case (op)
            2'b01:   q = (longint'(s) * d) % 65536;
            2'b10:   q = longint'(s) / d;
            2'b11: begin
                v = (s >= 16'h8000) ? longint'(s) - 65536 : longint'(s);
                q = (v >= 0) ? v / d : -((-v + d - 1) / d);
            end
            default: q = longint'(s);
        endcase
        return q[15:0];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                m_vld[d][p] = 1'b0;
                m_res[d][p] = 16'h0;
                m_zr[d][p]  = 1'b0;
            end
            m_last[d] = 1;
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        logic       elig [2];
        logic       g    [2];
        logic [15:0] r;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) elig[p] = req[p] && (!m_vld[d][p] || rdy[p]);
            g[0] = 1'b0;
            g[1] = 1'b0;
            if (!rst) begin
                if (elig[0] && elig[1]) begin
                    if (d == 1) g[0] = 1'b1;
                    else begin
                        g[0] = (m_last[d] == 1);
                        g[1] = (m_last[d] == 0);
                    end
                end else begin
                    g[0] = elig[0];
                    g[1] = elig[1];
                end
            end
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("gnt dut%0d port%0d", d, p), d_gnt[d][p], g[p]);
                chk($sformatf("vld dut%0d port%0d", d, p), d_vld[d][p], m_vld[d][p]);
                if (m_vld[d][p]) begin
                    chk($sformatf("res dut%0d port%0d", d, p), d_res[d][p], m_res[d][p]);
                    chk($sformatf("zr dut%0d port%0d", d, p), d_zr[d][p], m_zr[d][p]);
                end
                s_gnt[d][p] = d_gnt[d][p];
            end
            if (rst) begin
                for (int p = 0; p < 2; p++) begin
                    m_vld[d][p] = 1'b0;
                    m_res[d][p] = 16'h0;
                    m_zr[d][p]  = 1'b0;
                end
                m_last[d] = 1;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (g[p]) begin
                        r = ref_shift(src[p], shamt[p], dir[p]);
                        m_vld[d][p] = 1'b1;
                        m_res[d][p] = r;
                        m_zr[d][p]  = (r == 16'h0);
                        m_last[d]   = p;
                    end else if (m_vld[d][p] && rdy[p]) begin
                        m_vld[d][p] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; src[p] = 16'h0; shamt[p] = 4'h0; dir[p] = 2'b00; rdy[p] = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic [15:0] src;
        logic [3:0]  shamt;
        logic [1:0]  dir;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[10];
    logic [15:0] held;

    initial begin
        vt[0] = '{0, 16'h8001, 4'd1,  2'b11, 16'hC000};
        vt[1] = '{1, 16'h00F0, 4'd8,  2'b10, 16'h0000};
        vt[2] = '{1, 16'h0000, 4'd5,  2'b00, 16'h0000};
        vt[3] = '{0, 16'h1234, 4'd4,  2'b01, 16'h2340};
        vt[4] = '{0, 16'h1234, 4'd0,  2'b11, 16'h1234};
        vt[5] = '{0, 16'h8000, 4'd15, 2'b11, 16'hFFFF};
        vt[6] = '{0, 16'h8000, 4'd15, 2'b10, 16'h0001};
        vt[7] = '{1, 16'hFFFF, 4'd15, 2'b01, 16'h8000};
        vt[8] = '{1, 16'h7FFF, 4'd3,  2'b11, 16'h0FFF};
        vt[9] = '{1, 16'hABCD, 4'd7,  2'b00, 16'hABCD};

        idle_inputs();
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                chk("reset vld", d_vld[d][p], 0);
                chk("reset res", d_res[d][p], 0);
                chk("reset zr", d_zr[d][p], 0);
            end

        // Single-port operations with known results, one cycle grant-to-valid.
        for (int i = 0; i < 10; i++) begin
            int p;
            p = vt[i].port;
            req[p] = 1'b1; src[p] = vt[i].src; shamt[p] = vt[i].shamt; dir[p] = vt[i].dir;
            cycle();
            chk($sformatf("vec%0d gnt fair", i), s_gnt[0][p], 1);
            chk($sformatf("vec%0d gnt prio", i), s_gnt[1][p], 1);
            req[p] = 1'b0; src[p] = 16'h5555;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("vec%0d vld", i), d_vld[d][p], 1);
                chk($sformatf("vec%0d res", i), d_res[d][p], vt[i].exp);
                chk($sformatf("vec%0d zr", i), d_zr[d][p], (vt[i].exp == 16'h0) ? 1 : 0);
            end
            cycle();
        end

        // Sustained tie: round-robin alternates starting with A, fixed priority always A.
        do_reset();
        req[0] = 1'b1; req[1] = 1'b1; src[0] = 16'h0011; src[1] = 16'h0022;
        dir[0] = 2'b01; dir[1] = 2'b10; shamt[0] = 4'd1; shamt[1] = 4'd1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("tie%0d fair a", i), s_gnt[0][0], (i % 2 == 0) ? 1 : 0);
            chk($sformatf("tie%0d fair b", i), s_gnt[0][1], (i % 2 == 1) ? 1 : 0);
            chk($sformatf("tie%0d prio a", i), s_gnt[1][0], 1);
            chk($sformatf("tie%0d prio b", i), s_gnt[1][1], 0);
        end

        // Backpressure on A must not stall B; A regains service when rdy returns.
        idle_inputs();
        do_reset();
        req[0] = 1'b1; src[0] = 16'h0F00; dir[0] = 2'b10; shamt[0] = 4'd4;
        cycle();
        held = 16'h00F0;
        rdy[0] = 1'b0; src[0] = 16'hFFFF; dir[0] = 2'b01;
        req[1] = 1'b1; src[1] = 16'h0003; dir[1] = 2'b01; shamt[1] = 4'd2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("bp%0d a_gnt", i), s_gnt[0][0], 0);
            chk($sformatf("bp%0d b_gnt", i), s_gnt[0][1], 1);
            chk($sformatf("bp%0d a_res", i), d_res[0][0], held);
            chk($sformatf("bp%0d a_vld", i), d_vld[0][0], 1);
        end
        rdy[0] = 1'b1;
        cycle();
        chk("bp release a_gnt", s_gnt[0][0], 1);
        chk("bp release a_res", d_res[0][0], 16'hFFF0);

        // Reset while A is stalled and grants are pending.
        rdy[0] = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        chk("rst a_gnt", s_gnt[0][0], 0);
        chk("rst b_gnt", s_gnt[0][1], 0);
        rst = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                chk("midrst vld", d_vld[d][p], 0);
                chk("midrst res", d_res[d][p], 0);
                chk("midrst zr", d_zr[d][p], 0);
            end
        rdy[0] = 1'b1;
        cycle();
        chk("post-rst tie a", s_gnt[0][0], 1);
        chk("post-rst tie b", s_gnt[0][1], 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                req[p]   = ($urandom_range(0, 3) != 0);
                rdy[p]   = ($urandom_range(0, 2) != 0);
                src[p]   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
                shamt[p] = 4'($urandom);
                dir[p]   = 2'($urandom);
            end
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
